// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: queues 8-bit address/data requests and runs them in order as 16-bit SPI mode-0 frames on three address-mapped slaves
// Ports: clk/reset (async active-low); req_valid/req_ready/req_addr/req_data/req_rw request side;
// rsp_valid/rsp_data/rsp_slave read response; sclk/mosi/miso/cs_n SPI pins; busy and fifo_level status.
module spi_txn_scheduler #(
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2,
  parameter int S1_MAX  = 90,
  parameter int S2_MAX  = 170
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_addr,
  input  logic [7:0]               req_data,
  input  logic                     req_rw,
  output logic                     rsp_valid,
  output logic [7:0]               rsp_data,
  output logic [1:0]               rsp_slave,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic [2:0]               cs_n,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, GAP = 2'd3;
  localparam logic [7:0] B1 = 8'(S1_MAX + 1), B2 = 8'(S2_MAX + 1);
  localparam logic [15:0] DIV_END = 16'(CLK_DIV - 1);
  logic [7:0]    f_addr [DEPTH];
  logic [7:0]    f_data [DEPTH];
  logic          f_rw   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    state;
  logic [15:0]   div_cnt;
  logic          hi;
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;
  logic [7:0]    rx;
  logic          cur_rw;
  logic [1:0]    cur_slave;
  logic          push, pop, div_end, framing;
  logic [7:0]    h_addr;
  logic [1:0]    h_slave;
  logic [6:0]    h_off;
  assign req_ready = fifo_level != (AW+1)'(DEPTH);
  assign push      = req_valid && req_ready;
  assign pop       = state == IDLE && fifo_level != '0;
  assign div_end   = div_cnt == DIV_END;
  assign framing   = state == SETUP || state == SHIFT;
  assign h_addr    = f_addr[rd_ptr];
  assign h_slave   = h_addr <= 8'(S1_MAX) ? 2'd0 : h_addr <= 8'(S2_MAX) ? 2'd1 : 2'd2;
  assign h_off     = 7'(h_addr - (h_slave == 2'd0 ? 8'd0 : h_slave == 2'd1 ? B1 : B2));
  assign sclk      = state == SHIFT && hi;
  assign mosi      = framing && shreg[15];
  assign cs_n      = framing ? ~(3'b001 << cur_slave) : 3'b111;
  assign busy      = state != IDLE || fifo_level != '0;
  always_ff @(posedge clk)
    if (push) begin
      f_addr[wr_ptr] <= req_addr;
      f_data[wr_ptr] <= req_data;
      f_rw[wr_ptr]   <= req_rw;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  // miso is sampled as sclk rises into bits 8..15, i.e. a full low phase after the slave shifted it out
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      hi        <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx        <= '0;
      cur_rw    <= 1'b0;
      cur_slave <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_slave <= '0;
    end else begin
      rsp_valid <= 1'b0;
      div_cnt   <= (state == IDLE || div_end) ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE: if (pop) begin
          state     <= SETUP;
          cur_rw    <= f_rw[rd_ptr];
          cur_slave <= h_slave;
          shreg     <= {f_rw[rd_ptr], h_off, f_rw[rd_ptr] ? f_data[rd_ptr] : 8'h00};
        end
        SETUP: if (div_end) begin
          state   <= SHIFT;
          hi      <= 1'b1;
          bit_cnt <= '0;
        end
        SHIFT: if (div_end) begin
          if (hi) begin
            hi    <= 1'b0;
            shreg <= {shreg[14:0], 1'b0};
          end else if (bit_cnt == 4'd15) begin
            state     <= GAP;
            rsp_valid <= !cur_rw;
            rsp_data  <= cur_rw ? rsp_data : rx;
            rsp_slave <= cur_rw ? rsp_slave : cur_slave;
          end else begin
            hi      <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
            rx      <= (!cur_rw && bit_cnt >= 4'd7) ? {rx[6:0], miso} : rx;
          end
        end
        default: if (div_end) state <= IDLE;
      endcase
    end
endmodule

// File: doc/spi_txn_scheduler.md
# spi_txn_scheduler

Transaction scheduler that places the three address-mapped SPI slaves (ranges 0–90, 91–170, 171–255) on one shared serial bus. It sits between the APB-side bridge and the SPI pins. It queues 8-bit address/data requests in a small FIFO, decodes each address to one slave select, serializes a 16-bit SPI mode-0 frame, and returns read bytes with a one-cycle valid pulse.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries; power of 2, ≥2.
- CLK_DIV, 2: sclk half-period in clk cycles; ≥1.
- S1_MAX, 90: last address of slave 0.
- S2_MAX, 170: last address of slave 1; slave 2 spans S2_MAX+1..255. Each range is at most 128 addresses.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  equals !fifo_full.
- req_addr  input  8  global SPI address.
- req_data  input  8  write byte; ignored for reads.
- req_rw  input  1  1 = write, 0 = read.
- rsp_valid  output  1  one-cycle pulse when read data is available.
- rsp_data  output  8  read byte; held until the next rsp_valid.
- rsp_slave  output  2  slave index of the last response.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  serial out, MSB first.
- miso  input  1  serial in; shared by all slaves.
- cs_n  output  3  active-low slave selects; at most one bit low.
- busy  output  1  high when state≠IDLE or the FIFO is not empty.
- fifo_level  output  $clog2(DEPTH)+1  number of queued entries.

## Operation
- FIFO push happens when req_valid && req_ready.
  - A push while full is never accepted, even in a cycle that also pops.
  - Entries are served strictly in arrival order.
- State machine: IDLE → SETUP → SHIFT → GAP → IDLE.
  - IDLE: if the FIFO is not empty, pop the entry, latch it, go to SETUP. An entry pushed in this cycle is not visible until the next cycle.
  - SETUP: lasts CLK_DIV cycles. Selected cs_n bit low, sclk=0, mosi=frame[15].
  - SHIFT: 16 bits. Each bit is CLK_DIV cycles with sclk high, then CLK_DIV cycles with sclk low.
    - The slave samples on the rising edge.
    - mosi advances to the next bit on the falling edge.
    - After the 16th low phase, go to GAP.
  - GAP: lasts CLK_DIV cycles. cs_n=3'b111, sclk=0, mosi=0.
- Address decode:
  - addr ≤ S1_MAX: slave 0, base 0.
  - addr ≤ S2_MAX: slave 1, base S1_MAX+1.
  - otherwise: slave 2, base S2_MAX+1.
  - offset = addr − base, truncated to 7 bits.
- Frame layout: {rw, offset[6:0], payload[7:0]}.
  - payload = req_data for writes, 8'h00 for reads.
- Read capture: the scheduler samples miso at the sclk rising edges of bits 8..15 and assembles rsp_data MSB first. miso is ignored during bits 0..7 and for writes.
- Response: reads pulse rsp_valid in the first GAP cycle, with rsp_slave set. Writes produce no response.

## Timing
- Reset values, while reset is low:
  - cs_n=3'b111, sclk=0, mosi=0.
  - rsp_valid=0, rsp_data=0, rsp_slave=0.
  - fifo_level=0, busy=0, req_ready=1.
  - state=IDLE.
- Reset during any state:
  - All outputs take their reset values immediately (asynchronous).
  - The FIFO and the in-flight transaction are discarded; no rsp_valid is produced.
- Latency with the block idle:
  - Request accepted at cycle t; pop at t+1; cs_n low from t+2.
  - cs_n stays low for 33·CLK_DIV cycles.
  - Read rsp_valid arrives at t+2+33·CLK_DIV.
- Back-to-back transactions:
  - cs_n is high for at least CLK_DIV+1 cycles between frames (GAP plus the IDLE pop cycle).
  - sclk is low at every cs_n edge.
- fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.

## Test plan
- Write, CLK_DIV=2, addr 0x05, data 0xA5:
  - cs_n=3'b110.
  - mosi carries 0x85A5 over 16 rising edges.
  - cs_n is low for 66 cycles; no rsp_valid.
- Read addr 100, miso model returns 0x3C:
  - cs_n=3'b101, frame 0x0900.
  - Exactly one rsp_valid, with rsp_data=0x3C and rsp_slave=1.
- Decode boundaries (addr → slave/offset):
  - 90 → 0/0x5A.
  - 91 → 1/0x00.
  - 170 → 1/0x4F.
  - 171 → 2/0x00.
  - 255 → 2/0x54.
- Six back-to-back pushes from idle, DEPTH=4:
  - Request 1 is popped immediately; requests 2–5 are accepted and fifo_level reaches 4.
  - Request 6 waits with req_ready=0 until the next pop.
  - Frames appear in order, with cs_n high ≥3 cycles between them.
- Reset low during SHIFT bit 7:
  - cs_n=3'b111, sclk=0, fifo_level=0 in the same cycle.
  - No rsp_valid; no frame after release.
- Push while FIFO full with a same-cycle pop: the push is rejected and fifo_level drops by 1.
